// File: rtl/vector_pkg.sv
// Shared encodings, state type and default widths for the vector issue front-end.
// Imported by the issue controller and its done tracker.
package vector_pkg;

   localparam int LANES_DEF = 4;
   localparam int VLEN_DEF  = 8;
   localparam int VDW_DEF   = 8;
   localparam int ELS_DEF   = 8;
   localparam int OP_W_DEF  = 4;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_READ = 4'b1000,
      OP_FMA  = 4'b1111
   } op_e;

   // Opcode field view: write bit 3, scalar bit 2, alu field [1:0].
   typedef struct packed {
      logic       write;
      logic       scalar;
      logic [1:0] alu;
   } op_fields_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_COMPLETE
   } state_e;

endpackage

// File: rtl/lane_done_tracker.sv
// Sticky per-lane done mask; all_done_o folds in this cycle's done bits so the
// controller can move on the same cycle the last lane reports.
module lane_done_tracker
   import vector_pkg::*;
#(
   parameter int lanes_p = LANES_DEF
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic [lanes_p-1:0] done_i,
   output logic               all_done_o
);

   logic [lanes_p-1:0] mask_q;
   logic [lanes_p-1:0] merged;

   assign merged     = mask_q | (en_i ? done_i : '0);
   assign all_done_o = en_i & (&merged);

   always_ff @(posedge clk_i) begin
      if (reset_i || clr_i) begin
         mask_q <= '0;
      end else if (en_i) begin
         mask_q <= merged;
      end
   end

endmodule

// File: rtl/vector_issue_ctrl.sv
// Vector instruction front-end: accepts one instruction, broadcasts it to the lanes,
// gathers read beats and signals completion once every lane is done.
module vector_issue_ctrl
   import vector_pkg::*;
#(
   parameter int lanes_p    = LANES_DEF,
   parameter int vlen_p     = VLEN_DEF,
   parameter int vdw_p      = VDW_DEF,
   parameter int els_p      = ELS_DEF,
   parameter int op_width_p = OP_W_DEF
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       instr_v_i,
   output logic                       instr_ready_o,
   input  logic [op_width_p-1:0]      instr_op_i,
   input  logic [$clog2(els_p)-1:0]   instr_vd_i,
   input  logic [$clog2(els_p)-1:0]   instr_vs1_i,
   input  logic [$clog2(els_p)-1:0]   instr_vs2_i,
   input  logic [vdw_p-1:0]           instr_scalar_i,
   input  logic [vdw_p-1:0]           instr_w_data_i,
   output logic [op_width_p-1:0]      lane_op_o,
   output logic                       lane_start_o,
   output logic [vdw_p-1:0]           lane_scalar_o,
   output logic [vdw_p-1:0]           lane_w_data_o,
   output logic [$clog2(els_p)-1:0]   lane_vd_o,
   output logic [$clog2(els_p)-1:0]   lane_vs1_o,
   output logic [$clog2(els_p)-1:0]   lane_vs2_o,
   input  logic [lanes_p-1:0]         lane_done_i,
   input  logic [lanes_p-1:0]         lane_v_i,
   input  logic [lanes_p*vdw_p-1:0]   lane_r_data_i,
   output logic                       rd_v_o,
   output logic [lanes_p*vdw_p-1:0]   rd_data_o,
   output logic                       cmpl_v_o,
   output logic [op_width_p-1:0]      cmpl_op_o,
   output logic                       busy_o
);

   localparam int beats_lp  = vlen_p / lanes_p;
   localparam int beat_w_lp = $clog2(beats_lp + 1);

   state_e               state_q;
   logic [beat_w_lp-1:0] beat_cnt_q;
   logic                 all_done;
   logic                 lane_v_unused;

   // Lanes run in lockstep, so lane 0's valid alone qualifies a read beat.
   assign lane_v_unused = |lane_v_i[lanes_p-1:1];

   lane_done_tracker #(
      .lanes_p (lanes_p)
   ) u_done (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .clr_i      (state_q == ST_COMPLETE),
      .en_i       (state_q == ST_WAIT),
      .done_i     (lane_done_i),
      .all_done_o (all_done)
   );

   // The lane_* outputs double as the instruction latch.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         instr_ready_o <= 1'b1;
         busy_o        <= 1'b0;
         lane_start_o  <= 1'b0;
         lane_op_o     <= '0;
         lane_scalar_o <= '0;
         lane_w_data_o <= '0;
         lane_vd_o     <= '0;
         lane_vs1_o    <= '0;
         lane_vs2_o    <= '0;
         rd_v_o        <= 1'b0;
         rd_data_o     <= '0;
         cmpl_v_o      <= 1'b0;
         cmpl_op_o     <= '0;
         beat_cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register updates from pre-edge values.
         lane_start_o <= 1'b0;
         rd_v_o       <= 1'b0;
         cmpl_v_o     <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (instr_v_i) begin
                  lane_op_o     <= instr_op_i;
                  lane_scalar_o <= instr_scalar_i;
                  lane_w_data_o <= instr_w_data_i;
                  lane_vd_o     <= instr_vd_i;
                  lane_vs1_o    <= instr_vs1_i;
                  lane_vs2_o    <= instr_vs2_i;
                  instr_ready_o <= 1'b0;
                  busy_o        <= 1'b1;
                  lane_start_o  <= 1'b1;
                  state_q       <= ST_ISSUE;
               end
            end
            ST_ISSUE: state_q <= ST_WAIT;
            ST_WAIT: begin
               if (lane_op_o == op_width_p'(OP_READ) && lane_v_i[0] &&
                   beat_cnt_q < beat_w_lp'(beats_lp)) begin
                  rd_data_o  <= lane_r_data_i;
                  rd_v_o     <= 1'b1;
                  beat_cnt_q <= beat_cnt_q + beat_w_lp'(1);
               end
               if (all_done) begin
                  cmpl_v_o  <= 1'b1;
                  cmpl_op_o <= lane_op_o;
                  state_q   <= ST_COMPLETE;
               end
            end
            ST_COMPLETE: begin
               lane_op_o     <= '0;
               lane_scalar_o <= '0;
               lane_w_data_o <= '0;
               lane_vd_o     <= '0;
               lane_vs1_o    <= '0;
               lane_vs2_o    <= '0;
               cmpl_op_o     <= '0;
               beat_cnt_q    <= '0;
               busy_o        <= 1'b0;
               instr_ready_o <= 1'b1;
               state_q       <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_issue_ctrl.sv
// Randomized bench for vector_issue_ctrl: a per-instruction timeline model predicts
// every output cycle by cycle from the instruction and the lane done/beat schedule.
module tb_vector_issue_ctrl;
   import vector_pkg::*;

   localparam int LANES = 4;
   localparam int VLEN  = 8;
   localparam int VDW   = 8;
   localparam int ELS   = 8;
   localparam int OPW   = 4;
   localparam int RW    = $clog2(ELS);
   localparam int BEATS = VLEN / LANES;

   typedef int dly_t [LANES];

   logic                   clk_i = 1'b0;
   logic                   reset_i;
   logic                   instr_v_i;
   logic                   instr_ready_o;
   logic [OPW-1:0]         instr_op_i;
   logic [RW-1:0]          instr_vd_i, instr_vs1_i, instr_vs2_i;
   logic [VDW-1:0]         instr_scalar_i, instr_w_data_i;
   logic [OPW-1:0]         lane_op_o;
   logic                   lane_start_o;
   logic [VDW-1:0]         lane_scalar_o, lane_w_data_o;
   logic [RW-1:0]          lane_vd_o, lane_vs1_o, lane_vs2_o;
   logic [LANES-1:0]       lane_done_i, lane_v_i;
   logic [LANES*VDW-1:0]   lane_r_data_i;
   logic                   rd_v_o;
   logic [LANES*VDW-1:0]   rd_data_o;
   logic                   cmpl_v_o;
   logic [OPW-1:0]         cmpl_op_o;
   logic                   busy_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   vector_issue_ctrl #(
      .lanes_p(LANES), .vlen_p(VLEN), .vdw_p(VDW), .els_p(ELS), .op_width_p(OPW)
   ) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .instr_v_i      (instr_v_i),
      .instr_ready_o  (instr_ready_o),
      .instr_op_i     (instr_op_i),
      .instr_vd_i     (instr_vd_i),
      .instr_vs1_i    (instr_vs1_i),
      .instr_vs2_i    (instr_vs2_i),
      .instr_scalar_i (instr_scalar_i),
      .instr_w_data_i (instr_w_data_i),
      .lane_op_o      (lane_op_o),
      .lane_start_o   (lane_start_o),
      .lane_scalar_o  (lane_scalar_o),
      .lane_w_data_o  (lane_w_data_o),
      .lane_vd_o      (lane_vd_o),
      .lane_vs1_o     (lane_vs1_o),
      .lane_vs2_o     (lane_vs2_o),
      .lane_done_i    (lane_done_i),
      .lane_v_i       (lane_v_i),
      .lane_r_data_i  (lane_r_data_i),
      .rd_v_o         (rd_v_o),
      .rd_data_o      (rd_data_o),
      .cmpl_v_o       (cmpl_v_o),
      .cmpl_op_o      (cmpl_op_o),
      .busy_o         (busy_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " ready"},   64'(instr_ready_o), 64'd1);
      check({tag, " start"},   64'(lane_start_o),  64'd0);
      check({tag, " busy"},    64'(busy_o),        64'd0);
      check({tag, " cmpl_v"},  64'(cmpl_v_o),      64'd0);
      check({tag, " cmpl_op"}, 64'(cmpl_op_o),     64'd0);
      check({tag, " rd_v"},    64'(rd_v_o),        64'd0);
      check({tag, " rd_data"}, 64'(rd_data_o),     64'd0);
      check({tag, " lane_op"}, 64'(lane_op_o),     64'd0);
      check({tag, " lane_sc"}, 64'(lane_scalar_o), 64'd0);
      check({tag, " lane_wd"}, 64'(lane_w_data_o), 64'd0);
      check({tag, " lane_vd"}, 64'({lane_vd_o, lane_vs1_o, lane_vs2_o}), 64'd0);
   endtask

   // Runs one instruction from acceptance to the IDLE cycle after completion. Cycle t=0
   // is the start cycle; completion lands one cycle after the last lane's done.
   task automatic do_instr(input logic [3:0] op, input dly_t done_at,
                           input logic [31:0] beat_mask, input bit fixed_data,
                           input bit noise, input bit hold_next, input logic [3:0] next_op);
      logic [RW-1:0]        vd, vs1, vs2;
      logic [VDW-1:0]       sc, wd;
      logic [LANES*VDW-1:0] cur_data, exp_rd_data;
      logic [LANES-1:0]     dn;
      bit                   exp_rd_v;
      bit                   on;
      int                   c, nbeats, waited;
      vd  = RW'($urandom);
      vs1 = RW'($urandom);
      vs2 = RW'($urandom);
      sc  = VDW'($urandom);
      wd  = VDW'($urandom);
      instr_op_i     = op;
      instr_vd_i     = vd;
      instr_vs1_i    = vs1;
      instr_vs2_i    = vs2;
      instr_scalar_i = sc;
      instr_w_data_i = wd;
      instr_v_i      = 1'b1;
      waited = 0;
      while (instr_ready_o !== 1'b1 && waited < 50) begin
         @(negedge clk_i);
         waited++;
      end
      check("accept_wait", 64'(waited), 64'd0);
      if (waited >= 50) begin
         instr_v_i = 1'b0;
         return;
      end
      @(negedge clk_i);
      c = 0;
      for (int k = 0; k < LANES; k++) if (done_at[k] > c) c = done_at[k];
      c++;
      exp_rd_v    = 1'b0;
      exp_rd_data = '0;
      nbeats      = 0;
      for (int t = 0; t <= c + 1; t++) begin
         on = (t <= c);
         check($sformatf("start t%0d", t),   64'(lane_start_o),  64'(t == 0));
         check($sformatf("busy t%0d", t),    64'(busy_o),        64'(on));
         check($sformatf("cmpl_v t%0d", t),  64'(cmpl_v_o),      64'(t == c));
         check($sformatf("cmpl_op t%0d", t), 64'(cmpl_op_o),     64'((t == c) ? op : 4'd0));
         check($sformatf("ready t%0d", t),   64'(instr_ready_o), 64'(t == c + 1));
         check($sformatf("lane_op t%0d", t), 64'(lane_op_o),     64'(on ? op : 4'd0));
         check($sformatf("lane_sc t%0d", t), 64'(lane_scalar_o), 64'(on ? sc : '0));
         check($sformatf("lane_wd t%0d", t), 64'(lane_w_data_o), 64'(on ? wd : '0));
         check($sformatf("lane_regs t%0d", t), 64'({lane_vd_o, lane_vs1_o, lane_vs2_o}),
               64'(on ? {vd, vs1, vs2} : '0));
         check($sformatf("rd_v t%0d", t),    64'(rd_v_o),        64'(exp_rd_v));
         if (exp_rd_v) check($sformatf("rd_data t%0d", t), 64'(rd_data_o), 64'(exp_rd_data));
         if (on) begin
            dn = '0;
            for (int k = 0; k < LANES; k++) begin
               if (done_at[k] == t) dn[k] = 1'b1;
               else if (noise && (t == 0 || t >= c || t > done_at[k]) &&
                        $urandom_range(2) == 0) dn[k] = 1'b1;
            end
            lane_done_i   = dn;
            cur_data      = fixed_data ? 32'h4433_2211 : LANES*VDW'($urandom);
            lane_r_data_i = cur_data;
            lane_v_i      = LANES'($urandom);
            lane_v_i[0]   = beat_mask[t];
            exp_rd_v = (op == OP_READ) && t >= 1 && t < c && beat_mask[t] && nbeats < BEATS;
            if (exp_rd_v) begin
               exp_rd_data = cur_data;
               nbeats++;
            end
            if (t == 0) begin
               if (hold_next) instr_op_i = next_op;
               else instr_v_i = 1'b0;
            end
            @(negedge clk_i);
         end
      end
   endtask

   task automatic reset_mid_wait();
      instr_op_i     = OP_READ;
      instr_vd_i     = RW'($urandom);
      instr_vs1_i    = RW'($urandom);
      instr_vs2_i    = RW'($urandom);
      instr_scalar_i = VDW'($urandom);
      instr_w_data_i = VDW'($urandom);
      instr_v_i      = 1'b1;
      check("rst pre ready", 64'(instr_ready_o), 64'd1);
      @(negedge clk_i);
      instr_v_i     = 1'b0;
      lane_done_i   = '0;
      lane_v_i      = '1;
      lane_r_data_i = LANES*VDW'($urandom);
      check("rst issue start", 64'(lane_start_o), 64'd1);
      repeat (2) @(negedge clk_i);
      check("rst wait busy", 64'(busy_o), 64'd1);
      reset_i     = 1'b1;
      lane_done_i = '1;
      @(negedge clk_i);
      check_idle("rst mid");
      reset_i = 1'b0;
      @(negedge clk_i);
      check("rst after cmpl_v", 64'(cmpl_v_o), 64'd0);
      check("rst after rd_v",   64'(rd_v_o),   64'd0);
      check("rst after busy",   64'(busy_o),   64'd0);
      lane_done_i = '0;
      lane_v_i    = '0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      dly_t       d;
      logic [3:0] op, pend_op;
      bit         pend, hold;

      reset_i        = 1'b1;
      instr_v_i      = 1'b0;
      instr_op_i     = '0;
      instr_vd_i     = '0;
      instr_vs1_i    = '0;
      instr_vs2_i    = '0;
      instr_scalar_i = '0;
      instr_w_data_i = '0;
      lane_done_i    = '0;
      lane_v_i       = '0;
      lane_r_data_i  = '0;
      repeat (2) @(negedge clk_i);
      check_idle("reset");
      reset_i = 1'b0;
      @(negedge clk_i);

      d = '{5, 5, 5, 5};
      do_instr(OP_ADD, d, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      d = '{4, 7, 5, 9};
      do_instr(OP_ADD, d, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      d = '{6, 6, 6, 6};
      do_instr(OP_READ, d, 32'b1_1100, 1'b1, 1'b0, 1'b0, 4'd0);
      d = '{3, 3, 3, 3};
      do_instr(OP_FMA, d, 32'hffff_ffff, 1'b0, 1'b0, 1'b1, OP_READ);
      d = '{4, 2, 3, 1};
      do_instr(OP_READ, d, 32'b0110, 1'b0, 1'b0, 1'b0, 4'd0);
      reset_mid_wait();
      d = '{2, 1, 1, 2};
      do_instr(OP_FMA, d, 32'hffff_ffff, 1'b0, 1'b1, 1'b0, 4'd0);

      pend    = 1'b0;
      pend_op = '0;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(3))
            0:       op = OP_ADD;
            1:       op = OP_READ;
            2:       op = OP_FMA;
            default: op = 4'($urandom_range(15));
         endcase
         if (pend) op = pend_op;
         for (int k = 0; k < LANES; k++) d[k] = $urandom_range(8, 1);
         hold    = ($urandom_range(3) == 0);
         pend_op = ($urandom_range(1) == 0) ? OP_READ : 4'($urandom_range(15));
         do_instr(op, d, $urandom, 1'b0, 1'b1, hold, pend_op);
         pend = hold;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/vector_issue_ctrl.md
Name: vector_issue_ctrl

Overview:
- Instruction front-end sitting directly upstream of the lane array.
- Accepts one vector instruction at a time over a valid/ready handshake and latches it.
- Broadcasts opcode, operand data and a one-cycle start pulse to all lanes, then holds opcode/data stable until every lane has reported done.
- Gathers per-lane read data into a wide result beat and emits a one-cycle completion pulse per instruction.

Parameters:
- lanes_p, 4, number of lanes driven; one done bit and one read-data slice per lane.
- vlen_p, 8, elements per vector; with lanes_p sets expected read beats, vlen_p/lanes_p.
- vdw_p, 8, bits per element.
- els_p, 8, vector registers; sets register-index width, clog2(els_p).
- op_width_p, 4, opcode width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- instr_v_i  in  1  instruction valid.
- instr_ready_o  out  1  instruction accepted when v&ready.
- instr_op_i  in  op_width_p  opcode.
- instr_vd_i / instr_vs1_i / instr_vs2_i  in  clog2(els_p) each  destination/source register indices.
- instr_scalar_i  in  vdw_p  scalar operand.
- instr_w_data_i  in  vdw_p  external write data.
- lane_op_o  out  op_width_p  opcode to lanes.
- lane_start_o  out  1  start pulse.
- lane_scalar_o  out  vdw_p  scalar to lanes.
- lane_w_data_o  out  vdw_p  write data to lanes.
- lane_vd_o / lane_vs1_o / lane_vs2_o  out  clog2(els_p) each  register-file bank selects.
- lane_done_i  in  lanes_p  per-lane done.
- lane_v_i  in  lanes_p  per-lane read valid.
- lane_r_data_i  in  lanes_p*vdw_p  packed read data; lane k in slice k.
- rd_v_o  out  1  read beat valid.
- rd_data_o  out  lanes_p*vdw_p  read beat.
- cmpl_v_o  out  1  instruction complete pulse.
- cmpl_op_o  out  op_width_p  opcode of completed instruction.
- busy_o  out  1  instruction in flight.

Behaviour:
- Reset: state IDLE; all outputs 0 except instr_ready_o=1. Latched instruction, done mask and beat counter cleared.
- States and transitions:
  - IDLE: ready=1. On instr_v_i, latch all instr_* fields and go to ISSUE.
  - ISSUE: lane_start_o=1 for exactly this cycle; go to WAIT.
  - WAIT: done_mask |= lane_done_i. When (done_mask|lane_done_i) is all ones, go to COMPLETE.
  - COMPLETE: cmpl_v_o=1 and cmpl_op_o=latched op for one cycle; done mask cleared; go to IDLE.
- Latency and throughput:
  - Accept-to-start is 1 cycle.
  - Last lane done to cmpl_v_o is 1 cycle.
  - Minimum spacing between accepted instructions is 3 cycles plus lane latency.
- Stability: lane_op_o, lane_scalar_o, lane_w_data_o and lane_v*_o are driven from the latch and stay constant from ISSUE through COMPLETE. They are 0 in IDLE.
- busy_o is 1 in ISSUE, WAIT and COMPLETE.
- Read op (4'b1000) only: in WAIT, any cycle with lane_v_i[0]=1 registers lane_r_data_i and pulses rd_v_o the next cycle.
  - Beat counter increments per beat; it saturates at vlen_p/lanes_p.
  - Beats beyond vlen_p/lanes_p are dropped.
  - lane_v_i[k] for k≠0 is ignored; lanes run lockstep.
- Boundary conditions:
  - lane_done_i outside WAIT is ignored; the mask is not updated.
  - Done bits may arrive in any order or simultaneously.
  - A repeated done for the same lane is idempotent.
  - instr_v_i while not IDLE: no effect; ready=0 and the upstream holds.
  - reset_i mid-operation: back to IDLE next cycle; no cmpl_v_o or rd_v_o is produced.
  - Non-read op: rd_v_o stays 0 regardless of lane_v_i.

Decomposition:
- Package vector_pkg holds:
  - op encodings: OP_READ=4'b1000, OP_FMA=4'b1111, write bit 3, scalar bit 2, alu field [1:0];
  - the state enum;
  - width localparams.
- Sub-module lane_done_tracker (lanes_p): sticky mask with clear/enable inputs and an all_done output. All other logic stays in the top.

Test Plan:
- Reset: assert reset_i 2 cycles → instr_ready_o=1, all other outputs 0, busy_o=0.
- Add op 4'b0000, lanes report done together 5 cycles after start → lane_start_o pulses once; cmpl_v_o is 1 cycle after done with cmpl_op_o=0; lane_op_o is stable throughout.
- Staggered done: lanes 0..3 report done at cycles 4,7,5,9 after start → cmpl_v_o at cycle 10 only.
- Read op with lane_r_data_i slices = {8'h44,8'h33,8'h22,8'h11} on two beats → two rd_v_o pulses, data 32'h44332211 each; a third spurious beat is dropped.
- instr_v_i held high during WAIT with a second op → not accepted until IDLE; accepted the cycle after cmpl_v_o; both ops complete in order.
- reset_i asserted in WAIT → returns to IDLE; no cmpl_v_o; a new instruction is accepted normally afterwards.
